// File: rtl/modexp_pkg.sv
// Shared types and helpers for the modular exponentiation engine.
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MUL,
        SQR,
        DONE
    } modexp_state_t;

    // Iteration counter width. It is never narrower than one bit, so a
    // one-bit exponent still gets a legal counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiplicator.sv
// Combinational modular multiplier: o_prod = (i_a * i_b) mod i_mod.
// Both operands are expected to be below i_mod. A zero modulus yields 0.
module multiplicator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_mod,
    output logic [DATA_WIDTH-1:0] o_prod
);

    logic [2*DATA_WIDTH-1:0] w_full;
    logic [2*DATA_WIDTH-1:0] w_mod_ext;

    // Full-width product, then reduction. The zero-modulus guard keeps the
    // divider from seeing a zero divisor.
    always_comb begin
        w_full    = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
        w_mod_ext = {{DATA_WIDTH{1'b0}}, i_mod};
        o_prod    = '0;
        if (i_mod != '0) begin
            o_prod = DATA_WIDTH'(w_full % w_mod_ext);
        end
    end

endmodule

// File: rtl/modular_exponentiator.sv
// Constant-time right-to-left square-and-multiply engine computing
// result = base^exponent mod modulus with one time-shared modular multiplier.
// Every exponent bit costs one MUL and one SQR cycle whatever its value.
module modular_exponentiator
    import modexp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int EXP_WIDTH  = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [EXP_WIDTH-1:0]  exponent,
    input  logic [DATA_WIDTH-1:0] modulus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CNT_W = cnt_width(EXP_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXP_WIDTH - 1);

    modexp_state_t         r_state;
    logic [DATA_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [DATA_WIDTH-1:0] r_mod;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_err;
    logic                  r_done;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic [DATA_WIDTH-1:0] w_prod;

    // Select multiplier operands by state: reduce base in INIT, accumulate
    // in MUL, square in SQR.
    always_comb begin
        w_op_a = r_base;
        w_op_b = DATA_WIDTH'(1);
        case (r_state)
            MUL: begin
                w_op_a = r_acc;
                w_op_b = r_b;
            end
            SQR: begin
                w_op_a = r_b;
                w_op_b = r_b;
            end
            default: begin
                w_op_a = r_base;
                w_op_b = DATA_WIDTH'(1);
            end
        endcase
    end

    multiplicator #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mult (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_mod  (r_mod),
        .o_prod (w_prod)
    );

    // Control FSM and datapath registers. Outputs are registered and loaded
    // on the edge that enters DONE, so result/err are valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= base;
                        r_exp   <= exponent;
                        r_mod   <= modulus;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    if (r_mod == '0) begin
                        // Undefined modulus: report without touching the multiplier result.
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_b     <= w_prod;
                        r_acc   <= (r_mod == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    // Product is always computed; only the write is conditional.
                    if (r_exp[0]) begin
                        r_acc <= w_prod;
                    end
                    r_state <= SQR;
                end
                SQR: begin
                    r_b   <= w_prod;
                    r_exp <= r_exp >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_result <= r_acc;
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_state <= MUL;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;

endmodule

// File: tb/tb_modular_exponentiator.sv
// Directed-vector bench for modular_exponentiator at DATA_WIDTH 8 and 16.
module tb_modular_exponentiator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // 8-bit instance
    logic        d8_start = 1'b0;
    logic [7:0]  d8_base = '0, d8_exp = '0, d8_mod = '0;
    logic        d8_busy, d8_done, d8_err;
    logic [7:0]  d8_result;

    // 16-bit instance
    logic        d16_start = 1'b0;
    logic [15:0] d16_base = '0, d16_exp = '0, d16_mod = '0;
    logic        d16_busy, d16_done, d16_err;
    logic [15:0] d16_result;

    modular_exponentiator #(.DATA_WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (d8_start),
        .base     (d8_base),
        .exponent (d8_exp),
        .modulus  (d8_mod),
        .busy     (d8_busy),
        .done     (d8_done),
        .err      (d8_err),
        .result   (d8_result)
    );

    modular_exponentiator #(.DATA_WIDTH(16), .EXP_WIDTH(16)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (d16_start),
        .base     (d16_base),
        .exponent (d16_exp),
        .modulus  (d16_mod),
        .busy     (d16_busy),
        .done     (d16_done),
        .err      (d16_err),
        .result   (d16_result)
    );

    bit          sel = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_result;

    assign o_busy   = sel ? d16_busy   : d8_busy;
    assign o_done   = sel ? d16_done   : d8_done;
    assign o_err    = sel ? d16_err    : d8_err;
    assign o_result = sel ? d16_result : {8'h00, d8_result};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive_start(input bit s, input logic [15:0] b, input logic [15:0] e,
                               input logic [15:0] m);
        if (s) begin
            d16_base = b; d16_exp = e; d16_mod = m; d16_start = 1'b1;
        end else begin
            d8_base = b[7:0]; d8_exp = e[7:0]; d8_mod = m[7:0]; d8_start = 1'b1;
        end
    endtask

    // One full transaction: start, track latency and busy, check outputs,
    // then one more cycle to confirm the done pulse ends and result holds.
    // poke_at > 0 pulses start with junk operands at that cycle of the run.
    task automatic run(input string tag, input bit s, input logic [15:0] b,
                       input logic [15:0] e, input logic [15:0] m,
                       input logic [15:0] x_res, input bit x_err, input int x_lat,
                       input int poke_at);
        int  n;
        bit  drop;
        @(negedge clk);
        sel = s;
        drive_start(s, b, e, m);
        @(posedge clk);
        #1;
        d8_start = 1'b0;
        d16_start = 1'b0;
        chk({tag, "_accept_busy"}, 32'(o_busy), 32'd1);
        n = 0;
        drop = 1'b0;
        while (!o_done && n < 200) begin
            if (!o_busy) drop = 1'b1;
            if (n == poke_at) drive_start(s, 16'd3, 16'd255, 16'd11);
            @(posedge clk);
            #1;
            d8_start = 1'b0;
            d16_start = 1'b0;
            n++;
        end
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(x_lat));
        chk({tag, "_result"}, 32'(o_result), 32'(x_res));
        chk({tag, "_err"}, 32'(o_err), 32'(x_err));
        chk({tag, "_busy_held"}, 32'(drop), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "_err_clear"}, 32'(o_err), 32'd0);
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
        chk({tag, "_hold"}, 32'(o_result), 32'(x_res));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy8", 32'(d8_busy), 32'd0);
        chk("rst_done8", 32'(d8_done), 32'd0);
        chk("rst_err8", 32'(d8_err), 32'd0);
        chk("rst_result8", 32'(d8_result), 32'd0);
        chk("rst_busy16", 32'(d16_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5^3 mod 13 = 125 mod 13 = 8; latency 2*8+1
        run("pow5_3", 1'b0, 16'd5, 16'd3, 16'd13, 16'd8, 1'b0, 17, -1);
        // base >= modulus: 200 mod 7 = 4, 4^2 = 16 mod 7 = 2 (back-to-back start)
        run("big_base", 1'b0, 16'd200, 16'd2, 16'd7, 16'd2, 1'b0, 17, -1);
        // exponent zero: 1 mod 13 = 1
        run("exp0", 1'b0, 16'd7, 16'd0, 16'd13, 16'd1, 1'b0, 17, -1);
        // 16-bit: 4^13 mod 497 = 445; start re-pulsed mid-run is ignored
        run("w16", 1'b1, 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 33, 5);

        // Async reset in the middle of a run
        @(negedge clk);
        sel = 1'b0;
        drive_start(1'b0, 16'd5, 16'd3, 16'd13);
        @(posedge clk);
        #1;
        d8_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(d8_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(d8_busy), 32'd0);
        chk("midrst_result", 32'(d8_result), 32'd0);
        chk("midrst_done", 32'(d8_done), 32'd0);
        chk("midrst_result16", 32'(d16_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 1'b0, 16'd5, 16'd3, 16'd13, 16'd8, 1'b0, 17, -1);

        // modulus one: everything reduces to 0, no error
        run("mod1", 1'b0, 16'd9, 16'd5, 16'd1, 16'd0, 1'b0, 17, -1);
        // modulus zero: error after two edges
        run("mod0", 1'b0, 16'd9, 16'd5, 16'd0, 16'd0, 1'b1, 1, -1);
        // Recovery after error
        run("post_err", 1'b0, 16'd3, 16'd4, 16'd7, 16'd4, 1'b0, 17, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
